// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - four-master AHB bus arbiter with round-robin, hold limit and locked transfers
module ahb_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic [1:0] htrans,
    input  logic       hready,
    input  logic       hresp,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic       hmastlock,
    output logic       busy
);

    typedef enum logic [1:0] {PARK, OWN, LOCK, HANDOVER} state_t;

    localparam logic [8:0] HOLD_LIMIT = 9'(HOLD_MAX);

    state_t     state, state_nxt;
    logic [3:0] hgrant_nxt;
    logic [1:0] hmaster_nxt;
    logic       hmastlock_nxt;
    logic [8:0] beat_cnt, beat_cnt_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;

    logic [1:0] winner;
    logic [1:0] grant_idx;
    logic       owner_req;
    logic       owner_lock;
    logic       new_lock;

    assign owner_req  = hbusreq[rr_ptr];
    assign owner_lock = hlock[rr_ptr] & owner_req;
    assign grant_idx  = {hgrant[3] | hgrant[2], hgrant[3] | hgrant[1]};
    assign new_lock   = hlock[grant_idx] & hbusreq[grant_idx];
    assign busy       = hresetn & ((|hbusreq) | (state != PARK));

    // Round-robin search: owner+1 first, the owner itself last; no requester falls back to master 0.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + k[1:0];
            if (!found && hbusreq[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        hgrant_nxt    = hgrant;
        hmaster_nxt   = hmaster;
        hmastlock_nxt = hmastlock;
        beat_cnt_nxt  = beat_cnt;
        rr_ptr_nxt    = rr_ptr;
        if (hready) begin
            if (state == HANDOVER) begin
                hmaster_nxt   = grant_idx;
                rr_ptr_nxt    = grant_idx;
                hmastlock_nxt = new_lock;
                beat_cnt_nxt  = 9'd0;
                if (new_lock)
                    state_nxt = LOCK;
                else if (hbusreq[grant_idx])
                    state_nxt = OWN;
                else
                    state_nxt = PARK;
            end else begin
                if (htrans[1] && (beat_cnt < HOLD_LIMIT))
                    beat_cnt_nxt = beat_cnt + 9'd1;
                // A locked owner keeps the bus until its lock drops or an ERROR response breaks it.
                if ((state != LOCK) || !owner_lock || hresp) begin
                    if (!owner_req || (beat_cnt == HOLD_LIMIT) || hresp) begin
                        if (winner != rr_ptr) begin
                            hgrant_nxt = 4'b0001 << winner;
                            state_nxt  = HANDOVER;
                        end else begin
                            beat_cnt_nxt = 9'd0;
                            if (hbusreq == 4'b0000) begin
                                state_nxt     = PARK;
                                hmastlock_nxt = 1'b0;
                            end else if (owner_lock && !hresp) begin
                                state_nxt     = LOCK;
                                hmastlock_nxt = 1'b1;
                            end else begin
                                state_nxt     = OWN;
                                hmastlock_nxt = 1'b0;
                            end
                        end
                    end else if (owner_lock) begin
                        state_nxt     = LOCK;
                        hmastlock_nxt = 1'b1;
                    end else begin
                        state_nxt     = OWN;
                        hmastlock_nxt = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= PARK;
            hgrant    <= 4'b0001;
            hmaster   <= 2'd0;
            hmastlock <= 1'b0;
            beat_cnt  <= 9'd0;
            rr_ptr    <= 2'd0;
        end else begin
            state     <= state_nxt;
            hgrant    <= hgrant_nxt;
            hmaster   <= hmaster_nxt;
            hmastlock <= hmastlock_nxt;
            beat_cnt  <= beat_cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: max address-phase beats one master keeps the bus while others request; legal range 2..255.
REQ-002 SHALL have port hclk, input, 1: bus clock; all state updates on rising edge.
REQ-003 SHALL have port hresetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port hbusreq, input, 4: bus request, bit i from master i.
REQ-005 SHALL have port hlock, input, 4: locked-transfer request, bit i from master i; ignored when the matching hbusreq bit is 0.
REQ-006 SHALL have port htrans, input, 2: transfer type on the shared bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have port hready, input, 1: shared-bus transfer-complete, from the slave hreadyout mux.
REQ-008 SHALL have port hresp, input, 1: 1 = ERROR response.
REQ-009 SHALL have port hgrant, output, 4: one-hot grant, registered.
REQ-010 SHALL have port hmaster, output, 2: index of the master owning the address phase, registered.
REQ-011 SHALL have port hmastlock, output, 1: current address phase is locked, registered.
REQ-012 SHALL have port busy, output, 1: 1 when any hbusreq bit is 1 or state is not PARK.

Function
REQ-013 SHALL implement states PARK, OWN, LOCK and HANDOVER.
REQ-014 SHALL treat an arbitration point as any cycle with hready=1 in PARK or OWN, or in LOCK when the owner's hlock bit is 0.
REQ-015 SHALL, at an arbitration point, choose a winner only when the owner's hbusreq=0, or beat count = HOLD_MAX, or hresp=1.
REQ-016 SHALL pick the winner round-robin: search starts at owner+1 mod 4 and takes the first requesting master, with the owner checked last.
REQ-017 SHALL, when no master requests, grant master 0 (default master) and enter PARK.
REQ-018 SHALL, when the winner differs from the owner, update hgrant at the decision edge and enter HANDOVER.
REQ-019 SHALL, in HANDOVER, update hmaster and hmastlock from hgrant at the first edge with hready=1.
REQ-020 SHALL, on leaving HANDOVER, enter LOCK if the new owner's hlock=1, OWN if its hbusreq=1, and PARK otherwise.
REQ-021 SHALL, when the winner equals the owner, leave hgrant and hmaster unchanged and clear the beat count.
REQ-022 SHALL enter LOCK from OWN when hready=1 and the owner's hlock=1, and set hmastlock=1 at the same edge.
REQ-023 SHALL hold the grant in LOCK regardless of HOLD_MAX or other requests.
REQ-024 SHALL leave LOCK only via an arbitration point.
REQ-025 SHALL, when hresp=1 and hready=1 in LOCK, force an arbitration point at that edge, treating the owner's hlock as 0.
REQ-026 SHALL use a 9-bit beat counter that increments when hready=1 and htrans is NONSEQ or SEQ.
REQ-027 SHALL saturate the beat counter at HOLD_MAX.
REQ-028 SHALL clear the beat counter whenever hmaster changes.
REQ-029 SHALL not advance the beat counter on BUSY or IDLE beats.
REQ-030 SHALL make no decision, count no beat and update no hmaster while hready=0.
REQ-031 SHALL keep hgrant exactly one-hot in every cycle.
REQ-032 SHALL update the round-robin pointer to the new owner only when hmaster changes.

Reset
REQ-033 SHALL, while hresetn=0 and independent of hclk, force hgrant=0001, hmaster=00, hmastlock=0, busy=0, state=PARK, beat count=0, and round-robin pointer=0.
REQ-034 SHALL, on hresetn assertion mid-HANDOVER or mid-LOCK, abandon the pending transfer with no residual grant.
REQ-035 SHALL make its first decision at the first rising edge after hresetn deasserts.

Verification
REQ-036 Bench SHALL cover: reset, then hbusreq=0000, hready=1 for 5 cycles -> hgrant=0001, hmaster=0, busy=0.
REQ-037 Bench SHALL cover: hbusreq=0110 held, htrans=NONSEQ/SEQ, hready=1, HOLD_MAX=4 -> grant to master 1, then master 2 after 4 beats, then master 1; hmaster lags hgrant by one hready cycle each time.
REQ-038 Bench SHALL cover: master 3 owns with hlock=1, hbusreq=1111 for 40 beats -> hgrant stays 1000 and hmastlock=1 throughout; after hlock drops, the next arbitration point grants master 0.
REQ-039 Bench SHALL cover: hready=0 for 6 cycles during HANDOVER -> hmaster unchanged and beat count frozen; hmaster updates at the first hready=1 edge.
REQ-040 Bench SHALL cover: hresp=1 with hready=1 while master 2 is locked and master 0 requests -> hgrant=0001 at that edge, and hmastlock=0 after handover.
REQ-041 Bench SHALL cover: hresetn pulsed low asynchronously mid-LOCK -> outputs equal their reset values immediately, without waiting for a clock edge.
